// File: rtl/pc_redirect_unit.sv
// rtl/pc_redirect_unit.sv - PC stage aligning a late branch decision with its early-captured target
// Holds/advances the PC, redirects with a one-cycle flush on taken branches, supports stall and sticky halt.
module pc_redirect_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_INCR  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic [2:0]  brOp,
   input  logic [31:0] brTarget,
   input  logic        isBranch,
   input  logic        halt,
   output logic [31:0] pc,
   output logic        pcValid,
   output logic        flush,
   output logic        halted
);

   typedef enum logic [1:0] {RUN, BR_WAIT, BR_HOLD, HALT} state_t;

   localparam logic [31:0] INCR    = 32'(PC_INCR);
   localparam logic [31:0] PC_INIT = RESET_PC & 32'hFFFF_FFFC;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] tgt_q, tgt_d;
   logic        dec_q, dec_d;
   logic        halt_pend_q, halt_pend_d;
   logic        pc_valid_q, pc_valid_d;
   logic        flush_q, flush_d;
   logic        halted_q, halted_d;
   logic        taken;

   // The comparator decision is only live in BR_WAIT; after a stall we rely on the captured copy.
   assign taken = (state_q == BR_WAIT) ? isBranch : dec_q;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      tgt_d       = tgt_q;
      dec_d       = dec_q;
      halt_pend_d = halt_pend_q;
      pc_valid_d  = pc_valid_q;
      flush_d     = 1'b0;
      halted_d    = halted_q;
      case (state_q)
         RUN: begin
            if (halt || halt_pend_q) begin
               state_d    = HALT;
               pc_valid_d = 1'b0;
               halted_d   = 1'b1;
            end else if (stall) begin
               pc_valid_d = 1'b1;
            end else if (brOp != 3'b000) begin
               tgt_d      = brTarget & 32'hFFFF_FFFC;
               state_d    = BR_WAIT;
               pc_valid_d = 1'b0;
            end else begin
               pc_d       = pc_q + INCR;
               pc_valid_d = 1'b1;
            end
         end
         BR_WAIT, BR_HOLD: begin
            if (state_q == BR_WAIT) begin
               dec_d = isBranch;
            end
            if (halt) begin
               halt_pend_d = 1'b1;
            end
            if (stall) begin
               state_d = BR_HOLD;
            end else begin
               state_d    = RUN;
               pc_valid_d = 1'b1;
               if (taken) begin
                  pc_d    = tgt_q;
                  flush_d = 1'b1;
               end else begin
                  pc_d = pc_q + INCR;
               end
            end
         end
         default: begin
            pc_valid_d = 1'b0;
            halted_d   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         pc_q        <= PC_INIT;
         tgt_q       <= 32'h0;
         dec_q       <= 1'b0;
         halt_pend_q <= 1'b0;
         pc_valid_q  <= 1'b0;
         flush_q     <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         tgt_q       <= tgt_d;
         dec_q       <= dec_d;
         halt_pend_q <= halt_pend_d;
         pc_valid_q  <= pc_valid_d;
         flush_q     <= flush_d;
         halted_q    <= halted_d;
      end
   end

   assign pc      = pc_q;
   assign pcValid = pc_valid_q;
   assign flush   = flush_q;
   assign halted  = halted_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb/tb_pc_redirect_unit.sv - directed table-driven bench for pc_redirect_unit
module tb_pc_redirect_unit;

   logic        clk = 1'b0;
   logic        rst, stall, isBranch, halt;
   logic [2:0]  brOp;
   logic [31:0] brTarget;
   logic [31:0] pc;
   logic        pcValid, flush, halted;
   int          checks = 0;
   int          failures = 0;

   typedef struct {
      string       name;
      logic        rst;
      logic        stall;
      logic [2:0]  br_op;
      logic [31:0] br_tgt;
      logic        is_br;
      logic        halt;
      logic [31:0] exp_pc;
      logic        exp_valid;
      logic        exp_flush;
      logic        exp_halted;
   } vec_t;

   vec_t tbl[$];

   pc_redirect_unit #(.RESET_PC(32'h0000_0000), .PC_INCR(4)) dut (
      .clk(clk), .rst(rst), .stall(stall), .brOp(brOp), .brTarget(brTarget),
      .isBranch(isBranch), .halt(halt), .pc(pc), .pcValid(pcValid),
      .flush(flush), .halted(halted)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(string n, logic r, logic s, logic [2:0] op, logic [31:0] t,
                               logic ib, logic h, logic [31:0] epc, logic ev, logic ef, logic eh);
      vec_t v;
      v.name = n; v.rst = r; v.stall = s; v.br_op = op; v.br_tgt = t; v.is_br = ib; v.halt = h;
      v.exp_pc = epc; v.exp_valid = ev; v.exp_flush = ef; v.exp_halted = eh;
      return v;
   endfunction

   task automatic apply(input vec_t v);
      @(negedge clk);
      rst = v.rst; stall = v.stall; brOp = v.br_op; brTarget = v.br_tgt;
      isBranch = v.is_br; halt = v.halt;
      @(posedge clk);
      #1;
      checks++;
      if (pc !== v.exp_pc) begin
         failures++;
         $display("FAIL %s pc got=%h exp=%h", v.name, pc, v.exp_pc);
      end
      checks++;
      if (pcValid !== v.exp_valid) begin
         failures++;
         $display("FAIL %s pcValid got=%b exp=%b", v.name, pcValid, v.exp_valid);
      end
      checks++;
      if (flush !== v.exp_flush) begin
         failures++;
         $display("FAIL %s flush got=%b exp=%b", v.name, flush, v.exp_flush);
      end
      checks++;
      if (halted !== v.exp_halted) begin
         failures++;
         $display("FAIL %s halted got=%b exp=%b", v.name, halted, v.exp_halted);
      end
   endtask

   task automatic step(input string n, input logic r, input logic s, input logic [2:0] op,
                       input logic [31:0] t, input logic ib, input logic h,
                       input logic [31:0] epc, input logic ev, input logic ef, input logic eh);
      apply(mk(n, r, s, op, t, ib, h, epc, ev, ef, eh));
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; brOp = 3'b000; brTarget = 32'h0; isBranch = 1'b0; halt = 1'b0;

      //           name         rst stall op      target        isBr halt  pc            v  f  h
      tbl.push_back(mk("reset",    1, 0, 3'b000, 32'h0,        0, 0, 32'h0000_0000, 0, 0, 0));
      tbl.push_back(mk("run1",     0, 0, 3'b000, 32'h0,        0, 0, 32'h0000_0004, 1, 0, 0));
      tbl.push_back(mk("run2",     0, 0, 3'b000, 32'h0,        0, 0, 32'h0000_0008, 1, 0, 0));
      tbl.push_back(mk("run3",     0, 0, 3'b000, 32'h0,        0, 0, 32'h0000_000C, 1, 0, 0));
      tbl.push_back(mk("run4",     0, 0, 3'b000, 32'h0,        0, 0, 32'h0000_0010, 1, 0, 0));
      tbl.push_back(mk("t_reset",  1, 0, 3'b000, 32'h0,        0, 0, 32'h0000_0000, 0, 0, 0));
      tbl.push_back(mk("t_run1",   0, 0, 3'b000, 32'h0,        0, 0, 32'h0000_0004, 1, 0, 0));
      tbl.push_back(mk("t_run2",   0, 0, 3'b000, 32'h0,        0, 0, 32'h0000_0008, 1, 0, 0));
      tbl.push_back(mk("t_bubble", 0, 0, 3'b100, 32'h0000_0103, 0, 0, 32'h0000_0008, 0, 0, 0));
      tbl.push_back(mk("t_redir",  0, 0, 3'b000, 32'h0,        1, 0, 32'h0000_0100, 1, 1, 0));
      tbl.push_back(mk("t_after",  0, 0, 3'b000, 32'h0,        0, 0, 32'h0000_0104, 1, 0, 0));
      tbl.push_back(mk("n_reset",  1, 0, 3'b000, 32'h0,        0, 0, 32'h0000_0000, 0, 0, 0));
      tbl.push_back(mk("n_run1",   0, 0, 3'b000, 32'h0,        0, 0, 32'h0000_0004, 1, 0, 0));
      tbl.push_back(mk("n_run2",   0, 0, 3'b000, 32'h0,        0, 0, 32'h0000_0008, 1, 0, 0));
      tbl.push_back(mk("n_bubble", 0, 0, 3'b100, 32'h0000_0103, 0, 0, 32'h0000_0008, 0, 0, 0));
      tbl.push_back(mk("n_resolve",0, 0, 3'b000, 32'h0,        0, 0, 32'h0000_000C, 1, 0, 0));
      tbl.push_back(mk("w_bubble", 0, 0, 3'b001, 32'hFFFF_FFFF, 0, 0, 32'h0000_000C, 0, 0, 0));
      tbl.push_back(mk("w_redir",  0, 0, 3'b000, 32'h0,        1, 0, 32'hFFFF_FFFC, 1, 1, 0));
      tbl.push_back(mk("w_wrap",   0, 0, 3'b000, 32'h0,        0, 0, 32'h0000_0000, 1, 0, 0));
      tbl.push_back(mk("w_run",    0, 0, 3'b000, 32'h0,        0, 0, 32'h0000_0004, 1, 0, 0));
      tbl.push_back(mk("r_stall",  0, 1, 3'b000, 32'h0,        0, 0, 32'h0000_0004, 1, 0, 0));
      tbl.push_back(mk("h_prio",   0, 1, 3'b010, 32'h0000_0040, 1, 1, 32'h0000_0004, 0, 0, 1));
      tbl.push_back(mk("h_sticky", 0, 0, 3'b010, 32'h0000_0040, 1, 0, 32'h0000_0004, 0, 0, 1));
      tbl.push_back(mk("h_reset",  1, 0, 3'b000, 32'h0,        0, 0, 32'h0000_0000, 0, 0, 0));

      foreach (tbl[i]) apply(tbl[i]);

      // Taken branch stalled in BR_WAIT for three cycles; live isBranch drops meanwhile.
      step("s_run",    0, 0, 3'b000, 32'h0,        0, 0, 32'h0000_0004, 1, 0, 0);
      step("s_bubble", 0, 0, 3'b011, 32'h0000_0202, 0, 0, 32'h0000_0004, 0, 0, 0);
      step("s_wait",   0, 1, 3'b000, 32'h0,        1, 0, 32'h0000_0004, 0, 0, 0);
      step("s_hold1",  0, 1, 3'b000, 32'h0,        0, 0, 32'h0000_0004, 0, 0, 0);
      step("s_hold2",  0, 1, 3'b000, 32'h0,        0, 0, 32'h0000_0004, 0, 0, 0);
      step("s_redir",  0, 0, 3'b000, 32'h0,        0, 0, 32'h0000_0200, 1, 1, 0);
      step("s_after",  0, 0, 3'b000, 32'h0,        0, 0, 32'h0000_0204, 1, 0, 0);

      // Halt arriving in BR_WAIT: redirect first, then HALT with pc frozen.
      step("p_bubble", 0, 0, 3'b101, 32'h0000_0300, 0, 0, 32'h0000_0204, 0, 0, 0);
      step("p_redir",  0, 0, 3'b000, 32'h0,        1, 1, 32'h0000_0300, 1, 1, 0);
      step("p_halt",   0, 0, 3'b001, 32'h0000_0500, 0, 0, 32'h0000_0300, 0, 0, 1);
      step("p_frozen", 0, 0, 3'b000, 32'h0,        0, 0, 32'h0000_0300, 0, 0, 1);
      step("p_reset",  1, 0, 3'b000, 32'h0,        0, 0, 32'h0000_0000, 0, 0, 0);

      // Reset while parked in BR_HOLD discards the pending taken decision.
      step("c_run",    0, 0, 3'b000, 32'h0,        0, 0, 32'h0000_0004, 1, 0, 0);
      step("c_bubble", 0, 0, 3'b100, 32'h0000_0800, 0, 0, 32'h0000_0004, 0, 0, 0);
      step("c_wait",   0, 1, 3'b000, 32'h0,        1, 0, 32'h0000_0004, 0, 0, 0);
      step("c_reset",  1, 1, 3'b000, 32'h0,        1, 0, 32'h0000_0000, 0, 0, 0);
      step("c_run1",   0, 0, 3'b000, 32'h0,        1, 0, 32'h0000_0004, 1, 0, 0);
      step("c_run2",   0, 0, 3'b000, 32'h0,        0, 0, 32'h0000_0008, 1, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
